mem_cmd_responder: RTL and testbench

MEM_CMD_RESPONDER -- requirements
Module: mem_cmd_responder

---
 rtl/mem_cmd_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_cmd_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_responder.sv
// Command responder: turns ioDone edge requests into clear/read/write accesses on a back-end port.
// Optional access timeout with sticky errFlag is enabled by defining MEM_CMD_TIMEOUT_EN.
module mem_cmd_responder #(
  parameter int CLEAR_WORDS    = 1024,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [1:0]  modeIn,
  input  logic [24:0] memoryAddress,
  input  logic [15:0] ioDataIn,
  input  logic        ioDone,
  output logic        memDone,
  output logic [15:0] readData,
  output logic        readValid,
  output logic        errFlag,
  output logic [24:0] memAddr,
  output logic [15:0] memWdata,
  output logic        memWe,
  output logic        memRe,
  input  logic [15:0] memRdata,
  input  logic        memAck
);

  if (CLEAR_WORDS < 1 || CLEAR_WORDS > 33554431) begin : g_bad_clear_words
    $error("CLEAR_WORDS out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_e;

  localparam logic [24:0] LAST_WORD = 25'(CLEAR_WORDS - 1);

  state_e      state_q, state_d;
  logic        io_done_prev_q;
  logic [24:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [24:0] clr_cnt_q, clr_cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        req;
  logic        tmo_hit;
  logic        tmo_clr;

  assign req = ioDone & ~io_done_prev_q;

`ifdef MEM_CMD_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        err_q;

  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));
  assign errFlag = err_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (tmo_clr) begin
        tmo_q <= '0;
      end else if (state_q != IDLE) begin
        tmo_q <= tmo_q + 16'd1;
      end
      if (state_q != IDLE && !memAck && tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign errFlag = 1'b0;
`endif

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q        <= IDLE;
      io_done_prev_q <= 1'b1;
      addr_q         <= '0;
      data_q         <= '0;
      clr_cnt_q      <= '0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q        <= state_d;
      io_done_prev_q <= ioDone;
      addr_q         <= addr_d;
      data_q         <= data_d;
      clr_cnt_q      <= clr_cnt_d;
      rdata_q        <= rdata_d;
      rvalid_q       <= rvalid_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    clr_cnt_d = clr_cnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    tmo_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_clr = 1'b1;
        if (req) begin
          addr_d    = memoryAddress;
          data_d    = ioDataIn;
          clr_cnt_d = '0;
          unique case (modeIn)
            2'b00:   state_d = CLEAR;
            2'b01:   state_d = READ;
            2'b10:   state_d = WRITE;
            default: state_d = IDLE;
          endcase
        end
      end
      WRITE: begin
        if (memAck || tmo_hit) state_d = IDLE;
      end
      READ: begin
        if (memAck) begin
          rdata_d  = memRdata;
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (memAck) begin
          // Each acknowledged word starts a fresh strobe for the timeout counter.
          tmo_clr = 1'b1;
          if (clr_cnt_q == LAST_WORD) begin
            state_d = IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + 25'd1;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    memDone  = (state_q == IDLE);
    memWe    = (state_q == WRITE) || (state_q == CLEAR);
    memRe    = (state_q == READ);
    memAddr  = (state_q == CLEAR) ? clr_cnt_q : addr_q;
    memWdata = (state_q == WRITE) ? data_q : 16'h0000;
  end

  assign readData  = rdata_q;
  assign readValid = rvalid_q;

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed bench for mem_cmd_responder: write, read, clear, request edge rules, reset and timeout.
module tb_mem_cmd_responder;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  modeIn;
  logic [24:0] memoryAddress;
  logic [15:0] ioDataIn;
  logic        ioDone;
  logic        memDone;
  logic [15:0] readData;
  logic        readValid;
  logic        errFlag;
  logic [24:0] memAddr;
  logic [15:0] memWdata;
  logic        memWe;
  logic        memRe;
  logic [15:0] memRdata;
  logic        memAck;

  int vectors     = 0;
  int miscompares = 0;

  mem_cmd_responder #(.CLEAR_WORDS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstN(rstN), .modeIn(modeIn), .memoryAddress(memoryAddress),
    .ioDataIn(ioDataIn), .ioDone(ioDone), .memDone(memDone), .readData(readData),
    .readValid(readValid), .errFlag(errFlag), .memAddr(memAddr), .memWdata(memWdata),
    .memWe(memWe), .memRe(memRe), .memRdata(memRdata), .memAck(memAck)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"}, 32'(memDone), 32'd1);
    check({tag, "_we"},   32'(memWe),   32'd0);
    check({tag, "_re"},   32'(memRe),   32'd0);
  endtask

  initial begin
    rstN = 1'b0; ioDone = 1'b1; modeIn = 2'b10; memoryAddress = 25'h0000077;
    ioDataIn = 16'h1111; memRdata = 16'h0; memAck = 1'b0;
    tick(); tick();
    check("rst_addr",   32'(memAddr),   32'h0);
    check("rst_wdata",  32'(memWdata),  32'h0);
    check("rst_rdata",  32'(readData),  32'h0);
    check("rst_rvalid", 32'(readValid), 32'd0);
    check("rst_err",    32'(errFlag),   32'd0);
    check_idle("rst");

    // ioDone already high at reset release must not start a command.
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("rel_hi");
    end
    ioDone = 1'b0; tick();

    // Write with ack on the third strobe cycle.
    modeIn = 2'b10; memoryAddress = 25'h0001234; ioDataIn = 16'hBEEF; ioDone = 1'b1;
    tick();
    for (int c = 1; c <= 3; c++) begin
      check("wr_we",    32'(memWe),    32'd1);
      check("wr_re",    32'(memRe),    32'd0);
      check("wr_addr",  32'(memAddr),  32'h0001234);
      check("wr_wdata", 32'(memWdata), 32'hBEEF);
      check("wr_done",  32'(memDone),  32'd0);
      if (c == 3) memAck = 1'b1;
      tick();
    end
    memAck = 1'b0;
    check_idle("wr_end");
    // ioDone still held high: no re-trigger.
    tick(); check_idle("wr_hold");
    tick(); check_idle("wr_hold2");
    ioDone = 1'b0; tick();

    // Read of the top address, with a second request pulse mid-access.
    modeIn = 2'b01; memoryAddress = 25'h1FFFFFF; ioDone = 1'b1;
    tick();
    check("rd_re",   32'(memRe),   32'd1);
    check("rd_we",   32'(memWe),   32'd0);
    check("rd_addr", 32'(memAddr), 32'h1FFFFFF);
    check("rd_done", 32'(memDone), 32'd0);
    ioDone = 1'b0; tick();
    ioDone = 1'b1; tick();
    check("rd_mid_re", 32'(memRe), 32'd1);
    check("rd_mid_we", 32'(memWe), 32'd0);
    memRdata = 16'hA5A5; memAck = 1'b1;
    tick();
    memAck = 1'b0; memRdata = 16'h0000;
    check("rd_data",  32'(readData),  32'hA5A5);
    check("rd_valid", 32'(readValid), 32'd1);
    check_idle("rd_end");
    tick();
    check("rd_valid_off", 32'(readValid), 32'd0);
    check("rd_data_hold", 32'(readData),  32'hA5A5);
    check_idle("rd_after");
    ioDone = 1'b0; tick();

    // Stray ack in IDLE is ignored.
    memAck = 1'b1; tick();
    check("stray_rvalid", 32'(readValid), 32'd0);
    check_idle("stray");
    memAck = 1'b0;

    // No-op command.
    modeIn = 2'b11; ioDone = 1'b1; tick();
    check_idle("nop");
    tick(); check_idle("nop2");
    ioDone = 1'b0; tick();

    // Clear of 4 words, ack tied high; captured address ignored.
    memAck = 1'b1; modeIn = 2'b00; memoryAddress = 25'h0000155; ioDone = 1'b1;
    tick();
    for (int w = 0; w < 4; w++) begin
      check("clr_we",    32'(memWe),    32'd1);
      check("clr_addr",  32'(memAddr),  32'(w));
      check("clr_wdata", 32'(memWdata), 32'h0);
      check("clr_done",  32'(memDone),  32'd0);
      tick();
    end
    check_idle("clr_end");
    ioDone = 1'b0; memAck = 1'b0; tick();

    // Reset in the middle of a clear, at word 2.
    memAck = 1'b1; modeIn = 2'b00; ioDone = 1'b1;
    tick();
    ioDone = 1'b0;
    check("clrr_a0", 32'(memAddr), 32'd0);
    tick();
    check("clrr_a1", 32'(memAddr), 32'd1);
    tick();
    check("clrr_a2", 32'(memAddr), 32'd2);
    check("clrr_we", 32'(memWe),   32'd1);
    rstN = 1'b0; tick();
    check_idle("clrr_rst");
    check("clrr_rdata", 32'(readData), 32'h0);
    rstN = 1'b1; tick();
    check_idle("clrr_after");
    tick();
    check_idle("clrr_after2");
    memAck = 1'b0;

    // Access with no ack for longer than the timeout.
    modeIn = 2'b10; memoryAddress = 25'h0000005; ioDataIn = 16'h0001; ioDone = 1'b1;
    tick();
    ioDone = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("to_we", 32'(memWe), 32'd1);
      check("to_err_pre", 32'(errFlag), 32'd0);
      tick();
    end
`ifdef MEM_CMD_TIMEOUT_EN
    check_idle("to_abort");
    check("to_err", 32'(errFlag), 32'd1);
    tick(); tick();
    check("to_err_sticky", 32'(errFlag), 32'd1);
    rstN = 1'b0; tick();
    rstN = 1'b1;
    check("to_err_rst", 32'(errFlag), 32'd0);
`else
    for (int c = 0; c < 4; c++) begin
      check("to_we_wait", 32'(memWe),   32'd1);
      check("to_err_off", 32'(errFlag), 32'd0);
      tick();
    end
    memAck = 1'b1; tick();
    memAck = 1'b0;
    check_idle("to_late_ack");
    check("to_err_end", 32'(errFlag), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
